// File: rtl/vram_write_queue_pkg.sv
// vram_write_queue_pkg: shared state and entry types for the CPU-to-VRAM write queue
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif
package vram_write_queue_pkg;
  localparam int VRAM_ADDR_W = `VRAM_ADDR_WIDTH;
  typedef enum logic {IDLE, FILL} state_t;
  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [7:0]             data;
  } entry_t;
endpackage

// File: rtl/sync_fifo_showahead_m.sv
// sync_fifo_showahead_m: synchronous show-ahead FIFO, head visible combinationally
module sync_fifo_showahead_m #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = empty ? '0 : mem[rd_ptr];
  // storage is not reset; the head is masked to zero while empty
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  // pointers wrap at DEPTH because DEPTH is a power of two
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/vram_write_queue.sv
// vram_write_queue: buffers CPU byte writes and drains them onto the VRAM bus while writable; optional fill engine via VRAM_WRITE_QUEUE_FILL_EN
module vram_write_queue
  import vram_write_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ADDR_W = VRAM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   writable,
  input  logic                   cpu_valid,
  output logic                   cpu_ready,
  input  logic [ADDR_W-1:0]      cpu_address,
  input  logic [7:0]             cpu_data,
  output logic [ADDR_W-1:0]      address,
  output logic [7:0]             data,
  output logic                   write_enable,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   idle
`ifdef VRAM_WRITE_QUEUE_FILL_EN
  ,
  input  logic                   fill_start,
  input  logic [ADDR_W-1:0]      fill_base,
  input  logic [ADDR_W:0]        fill_len,
  input  logic [7:0]             fill_value,
  output logic                   fill_busy
`endif
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } slot_t;
  slot_t head, wr;
  logic empty, full, push, pop;
  state_t state;
  assign wr = '{addr: cpu_address, data: cpu_data};
  assign cpu_ready = !full;
  assign push = cpu_valid && cpu_ready;
  assign pop = !rst && writable && !empty && state == IDLE;
  assign idle = empty && state == IDLE;
  sync_fifo_showahead_m #(.WIDTH($bits(slot_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wdata(wr),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(pending)
  );
`ifdef VRAM_WRITE_QUEUE_FILL_EN
  logic [ADDR_W-1:0] fill_cur;
  logic [ADDR_W:0]   fill_rem;
  logic [7:0]        fill_val;
  assign fill_busy = state == FILL;
  assign write_enable = !rst && writable && (fill_busy || !empty);
  assign address = fill_busy ? fill_cur : head.addr;
  assign data = fill_busy ? fill_val : head.data;
  // fill engine: starts only from idle, writes one byte per writable cycle
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else if (state == IDLE) begin
      if (fill_start && empty && fill_len != '0) begin
        state <= FILL;
        fill_cur <= fill_base;
        fill_rem <= fill_len;
        fill_val <= fill_value;
      end
    end else if (writable) begin
      fill_cur <= fill_cur + 1'b1;
      fill_rem <= fill_rem - 1'b1;
      if (fill_rem == (ADDR_W+1)'(1)) state <= IDLE;
    end
`else
  assign state = IDLE;
  assign write_enable = !rst && writable && !empty;
  assign address = head.addr;
  assign data = head.data;
`endif
endmodule

// File: tb/tb_vram_write_queue.sv
// tb_vram_write_queue: table vectors, directed corner sequences and a queue-based reference model
`timescale 1ns/1ps
module tb_vram_write_queue;
  localparam int DEPTH = 16;
  localparam int AW = 12;
  localparam int PW = 5;
`ifdef VRAM_WRITE_QUEUE_FILL_EN
  localparam bit FILL_EN = 1;
`else
  localparam bit FILL_EN = 0;
`endif
  logic clk = 0;
  logic rst = 1, writable = 0, cpu_valid = 0, cpu_ready;
  logic [AW-1:0] cpu_address = '0, address;
  logic [7:0] cpu_data = '0, data;
  logic write_enable, idle, busy;
  logic [PW-1:0] pending;
  logic f_start = 0;
  logic [AW-1:0] f_base = '0;
  logic [AW:0] f_len = '0;
  logic [7:0] f_value = '0;
  always #5 clk = ~clk;
  vram_write_queue #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .writable(writable),
    .cpu_valid(cpu_valid),
    .cpu_ready(cpu_ready),
    .cpu_address(cpu_address),
    .cpu_data(cpu_data),
    .address(address),
    .data(data),
    .write_enable(write_enable),
    .pending(pending),
    .idle(idle)
`ifdef VRAM_WRITE_QUEUE_FILL_EN
    ,
    .fill_start(f_start),
    .fill_base(f_base),
    .fill_len(f_len),
    .fill_value(f_value),
    .fill_busy(busy)
`endif
  );
`ifndef VRAM_WRITE_QUEUE_FILL_EN
  assign busy = 1'b0;
`endif
  int vectors = 0, miscompares = 0;
  typedef struct packed {logic [AW-1:0] a; logic [7:0] d;} ent_t;
  ent_t q[$];
  ent_t wlog[$];
  bit m_fill = 0;
  int m_cur, m_rem, m_val;
  bit chk_en = 0;
  int busy_cnt = 0;
  logic s_we, s_ready, s_idle;
  logic [AW-1:0] s_addr;
  logic [7:0] s_data;
  logic [PW-1:0] s_pend;
  typedef struct {int w, v, a, d, we, rdy, pend, idl, ea, ed;} vec_t;
  vec_t tbl[11];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock cycle: drive at negedge, sample/compare before posedge, then advance the model
  task automatic cyc(bit r, bit w, bit v, int a, int d, bit fs = 0, int fb = 0, int fl = 0, int fv = 0);
    bit e_rdy, e_we, acc_fill;
    int e_a, e_d;
    @(negedge clk);
    rst = r; writable = w; cpu_valid = v;
    cpu_address = a[AW-1:0]; cpu_data = d[7:0];
    f_start = fs; f_base = fb[AW-1:0]; f_len = fl[AW:0]; f_value = fv[7:0];
    #3;
    s_we = write_enable; s_addr = address; s_data = data;
    s_ready = cpu_ready; s_pend = pending; s_idle = idle;
    if (write_enable === 1'b1) wlog.push_back({address, data});
    if (busy === 1'b1) busy_cnt++;
    e_rdy = q.size() < DEPTH;
    e_we = !r && w && (m_fill || q.size() > 0);
    e_a = m_fill ? m_cur : (q.size() > 0 ? int'(q[0].a) : 0);
    e_d = m_fill ? m_val : (q.size() > 0 ? int'(q[0].d) : 0);
    if (chk_en) begin
      check("cpu_ready", cpu_ready, e_rdy);
      check("pending", pending, q.size());
      check("idle", idle, q.size() == 0 && !m_fill);
      check("write_enable", write_enable, e_we);
      if (e_we) begin
        check("address", address, e_a);
        check("data", data, e_d);
      end
`ifdef VRAM_WRITE_QUEUE_FILL_EN
      check("fill_busy", busy, m_fill);
`endif
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      m_fill = 0;
    end else begin
      acc_fill = FILL_EN && fs && q.size() == 0 && !m_fill && fl != 0;
      if (m_fill && w) begin
        m_cur = (m_cur + 1) % (1 << AW);
        m_rem--;
        if (m_rem == 0) m_fill = 0;
      end else if (!m_fill && w && q.size() > 0) void'(q.pop_front());
      if (v && e_rdy) q.push_back({a[AW-1:0], d[7:0]});
      if (acc_fill) begin
        m_fill = 1; m_cur = fb; m_rem = fl; m_val = fv;
      end
    end
  endtask

  task automatic do_reset();
    chk_en = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk_en = 1;
    wlog.delete();
  endtask

  initial begin
    tbl = '{
      '{0, 1, 'h800, 'h12, 0, 1, 0, 1, 0, 0},
      '{0, 1, 'h801, 'h34, 0, 1, 1, 0, 'h800, 'h12},
      '{0, 1, 'h802, 'h56, 0, 1, 2, 0, 'h800, 'h12},
      '{0, 0, 0, 0, 0, 1, 3, 0, 'h800, 'h12},
      '{1, 0, 0, 0, 1, 1, 3, 0, 'h800, 'h12},
      '{1, 0, 0, 0, 1, 1, 2, 0, 'h801, 'h34},
      '{1, 0, 0, 0, 1, 1, 1, 0, 'h802, 'h56},
      '{1, 0, 0, 0, 0, 1, 0, 1, -1, -1},
      '{1, 1, 'h900, 'hAB, 0, 1, 0, 1, -1, -1},
      '{1, 0, 0, 0, 1, 1, 1, 0, 'h900, 'hAB},
      '{0, 0, 0, 0, 0, 1, 0, 1, -1, -1}
    };
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cyc(1'(tbl[i].w), 0, 0, 0, 0);
      vectors = vectors;
    end
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cyc(0, 1'(tbl[i].w), 1'(tbl[i].v), tbl[i].a, tbl[i].d);
      check($sformatf("tbl%0d_we", i), s_we, tbl[i].we);
      check($sformatf("tbl%0d_ready", i), s_ready, tbl[i].rdy);
      check($sformatf("tbl%0d_pending", i), s_pend, tbl[i].pend);
      check($sformatf("tbl%0d_idle", i), s_idle, tbl[i].idl);
      if (tbl[i].ea >= 0) begin
        check($sformatf("tbl%0d_addr", i), s_addr, tbl[i].ea);
        check($sformatf("tbl%0d_data", i), s_data, tbl[i].ed);
      end
    end
    // fill to DEPTH, push while full, pop once
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 'h100 + i, i);
    cyc(0, 0, 1, 'hABC, 'hEE);
    check("full_ready", s_ready, 0);
    check("full_pending", s_pend, DEPTH);
    cyc(0, 1, 1, 'hDDD, 'h77);
    check("full_pop_we", s_we, 1);
    check("full_pop_addr", s_addr, 'h100);
    check("full_pop_ready", s_ready, 0);
    cyc(0, 0, 0, 0, 0);
    check("after_pop_ready", s_ready, 1);
    check("after_pop_pending", s_pend, DEPTH - 1);
    // toggled writable drain of 8 entries
    do_reset();
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 'h200 + 3 * i, 'h40 + i);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1'(i % 2 == 0), 0, 0, 0);
      if (i % 2 == 1) check("toggle_no_we", s_we, 0);
    end
    check("toggle_count", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++)
      check($sformatf("toggle_entry%0d", i), wlog[i], {12'('h200 + 3 * i), 8'('h40 + i)});
    // continuous push with writable high: one cycle latency, occupancy <= 1
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 1, 'h400 + i, i);
      check("stream_pending", s_pend <= 1, 1);
      if (i > 0) begin
        check("stream_we", s_we, 1);
        check("stream_addr", s_addr, 'h400 + i - 1);
      end
    end
    // reset mid-drain discards queued entries
    do_reset();
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 'h300 + i, i);
    cyc(1, 1, 0, 0, 0);
    check("rst_cycle_we", s_we, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 0);
      check("post_rst_we", s_we, 0);
      check("post_rst_pending", s_pend, 0);
    end
`ifdef VRAM_WRITE_QUEUE_FILL_EN
    do_reset();
    busy_cnt = 0;
    cyc(0, 1, 0, 0, 0, 1, 'h800, 256, 'h00);
    for (int i = 0; i < 300; i++) cyc(0, 1, i == 10, 'h800, 'hAA);
    check("fill_busy_cycles", busy_cnt, 256);
    check("fill_writes", wlog.size(), 257);
    if (wlog.size() == 257) begin
      check("fill_first", wlog[0], {12'h800, 8'h00});
      check("fill_last", wlog[255], {12'h8FF, 8'h00});
      check("fill_cpu_after", wlog[256], {12'h800, 8'hAA});
    end
    wlog.delete();
    cyc(0, 1, 0, 0, 0, 1, 'hFFF, 2, 'h5A);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    check("wrap_count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("wrap_0", wlog[0], {12'hFFF, 8'h5A});
      check("wrap_1", wlog[1], {12'h000, 8'h5A});
    end
    wlog.delete();
    cyc(0, 1, 0, 0, 0, 1, 'h123, 0, 'h11);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    check("len0_writes", wlog.size(), 0);
    check("len0_idle", s_idle, 1);
`endif
    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit r, w, v, fs;
      r = $urandom_range(0, 249) == 0;
      w = $urandom_range(0, 99) < ((i / 500) % 2 ? 30 : 70);
      v = $urandom_range(0, 99) < 60;
      fs = $urandom_range(0, 99) == 0;
      cyc(r, w, v, $urandom_range(0, 4095), $urandom_range(0, 255),
          fs, $urandom_range(0, 4095), $urandom_range(0, 40), $urandom_range(0, 255));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vram_write_queue.md
Name: vram_write_queue

Overview:
- CPU-side producer for the VRAM write bus (data/address/write_enable) consumed by the foreground, background and other VRAM-holding renderers.
- Accepts CPU byte writes at any time through a valid/ready handshake and buffers them in a FIFO.
- Drains the FIFO onto the VRAM bus only while the video timing reports `writable`, so no CPU write is lost to the renderers' writable gating.
- Optionally provides a hardware fill engine for clearing or filling VRAM ranges, such as the object memory (OBM) or the foreground pattern memory (PMF).

Parameters:
- DEPTH, 16: FIFO entries; must be a power of 2, ≥2.
- ADDR_W, `VRAM_ADDR_WIDTH (12): VRAM address width.

Ports:
- clk  in  1  system clock (12.5875 MHz).
- rst  in  1  synchronous, active-high reset.
- writable  in  1  from video timing; VRAM writes allowed this cycle.
- cpu_valid  in  1  CPU write request.
- cpu_ready  out  1  queue can accept (not full).
- cpu_address  in  ADDR_W  CPU target VRAM address.
- cpu_data  in  8  CPU write byte.
- address  out  ADDR_W  VRAM bus address.
- data  out  8  VRAM bus data.
- write_enable  out  1  VRAM bus strobe.
- pending  out  $clog2(DEPTH)+1  current FIFO occupancy.
- idle  out  1  FIFO empty and no fill active.

Behaviour:
- Reset: FIFO empty (pending=0), state IDLE, idle=1, cpu_ready=1.
  - write_enable=0 during and after reset; address/data are don't-care while write_enable=0 but are driven from the FIFO head (0 after reset).
- FIFO is show-ahead:
  - Head entry drives address/data combinationally.
  - write_enable = writable && !empty && state==IDLE (combinational).
  - Consumer samples on the same clk edge; the entry pops on that edge.
  - Zero-cycle bus latency from writable rising when non-empty.
  - No write is issued in a cycle where writable=0.
- Push: on posedge when cpu_valid && cpu_ready.
  - Entry visible at head one cycle after push when the FIFO was empty.
  - cpu_ready = !full.
- Simultaneous push and pop:
  - When full: pop frees a slot but cpu_ready stays 0 that cycle (ready derived from the registered count, no ready-depends-on-writable path).
  - When empty: pushed entry is not popped the same cycle; it goes out next writable cycle.
- Ordering: strict FIFO; writes to the same address keep program order.
- Pointers: wrap modulo DEPTH; count is DEPTH+1-valued (0..DEPTH).
- writable falling mid-drain: remaining entries stall and resume on the next writable cycle, no loss or duplication.
- rst asserted mid-drain: queued entries discarded; write_enable=0 from the reset cycle on.
- idle = (pending==0) && state==IDLE.

Optional Feature:
- Macro: VRAM_WRITE_QUEUE_FILL_EN.
- With the macro, extra inputs are added:
  - fill_start (1): pulse.
  - fill_base (ADDR_W).
  - fill_len (ADDR_W+1): 0 = no-op.
  - fill_value (8).
  - Extra output fill_busy (1).
- fill_start is accepted only when idle=1 (ignored otherwise). It latches base/len/value and enters state FILL.
- FILL:
  - Every writable cycle drives address=cur, data=fill_value, write_enable=1; then cur++ and remaining--.
  - Leaves to IDLE after the write with remaining==1.
  - Address increments wrap modulo 2^ADDR_W.
- While FILL:
  - FIFO does not drain.
  - CPU pushes are still accepted until full; they drain after the fill, so CPU writes queued during a fill land after it.
- fill_busy = state==FILL.
- Without the macro: no extra ports, state is fixed IDLE, and the fill logic is absent.

Decomposition:
- Package vram_write_queue_pkg:
  - State enum {IDLE, FILL}.
  - Entry struct {addr[ADDR_W], data[8]}.
  - ADDR_W default is taken from `VRAM_ADDR_WIDTH in headers/parameters.vh.
- Sub-module sync_fifo_showahead_m:
  - Parameterized width/depth.
  - push/pop/full/empty/count.
  - Reused later by other CPU-to-GPU paths.

Test Plan:
- Reset, writable=0, push 3 writes (0x800←0x12, 0x801←0x34, 0x802←0x56) -> write_enable stays 0, pending=3. Raise writable -> three consecutive cycles with write_enable=1 in that order, then pending=0, idle=1.
- Push DEPTH=16 entries with writable=0 -> cpu_ready=0 after the 16th push. Push attempts while full are not accepted. Raise writable for 1 cycle -> one pop, cpu_ready=1 next cycle.
- Drain 8 entries with writable toggling 1,0,1,0… -> write_enable only in writable cycles. All 8 delivered once, in order. Scoreboard against a behavioural VRAM model.
- Continuous push every cycle with writable=1 from empty -> each entry appears on the bus exactly one cycle after its push. Steady-state throughput is one write per cycle; pending stays ≤1.
- Queue 5 entries, assert rst for 1 cycle while writable=1 -> write_enable=0 in the reset cycle and thereafter. pending=0, no stale writes.
- (FILL_EN) fill_base=0x800, fill_len=256, fill_value=0x00, writable=1 -> 256 writes covering 0x800..0x8FF, fill_busy 256 cycles. CPU push during the fill to 0x800←0xAA lands after address 0x8FF is written. fill_base=0xFFF, fill_len=2 -> writes 0xFFF then 0x000. fill_len=0 -> no writes.
